// File: rtl/im_loader_pkg.sv
// ============================================================================
// Module      : im_loader_pkg
// Description : Shared constants and state encoding for the instruction-memory
//               loader and the fetch unit's PC-to-index mapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package im_loader_pkg;

    localparam int          IM_DEPTH = 4096;
    localparam int          ADDR_W   = 12;
    localparam logic [31:0] PC_BASE  = 32'h0000_3000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    // Word index in the IM back to the byte PC the fetch unit uses for it.
    function automatic logic [31:0] word_to_pc(input logic [ADDR_W-1:0] idx);
        return PC_BASE + {{(30-ADDR_W){1'b0}}, idx, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/im_loader_if.sv
// ============================================================================
// Module      : im_loader_if
// Description : Byte-stream input, IM write port and status bundle of the
//               instruction-memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface im_loader_if #(
    parameter int ADDR_W = im_loader_pkg::ADDR_W
) ();

    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              in_last;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_reset;
    logic              done;
    logic              overflow;
    logic [ADDR_W:0]   word_count;

    modport master (
        output start, in_valid, in_data, in_last,
        input  in_ready, im_we, im_addr, im_wdata,
        input  cpu_reset, done, overflow, word_count
    );

    modport slave (
        input  start, in_valid, in_data, in_last,
        output in_ready, im_we, im_addr, im_wdata,
        output cpu_reset, done, overflow, word_count
    );

endinterface

`default_nettype wire

// File: rtl/im_word_packer.sv
// ============================================================================
// Module      : im_word_packer
// Description : Assembles MSB-first bytes into big-endian 32-bit words and
//               left-justifies a short final word, zero-filling the low bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module im_word_packer (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        i_clear,
    input  wire logic        i_accept,
    input  wire logic        i_last,
    input  wire logic [7:0]  i_data,
    output logic             o_word_done,
    output logic             o_word_valid,
    output logic [31:0]      o_word
);

    logic [23:0] r_sr;
    logic [1:0]  r_byte_idx;
    logic        r_word_valid;
    logic [31:0] r_word;

    logic [31:0] w_assembled;
    logic [4:0]  w_shamt;
    logic [31:0] w_padded;

    // Low bytes of the assembled value belong to the current word; shifting
    // left pushes stale bytes of the previous word out of the top.
    assign w_assembled = {r_sr, i_data};
    assign w_shamt     = {2'd3 - r_byte_idx, 3'b000};
    assign w_padded    = w_assembled << w_shamt;
    assign o_word_done = i_accept && ((r_byte_idx == 2'd3) || i_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr         <= '0;
            r_byte_idx   <= '0;
            r_word_valid <= 1'b0;
            r_word       <= '0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_sr       <= '0;
                r_byte_idx <= '0;
            end else if (i_accept) begin
                r_sr <= {r_sr[15:0], i_data};
                if (o_word_done) begin
                    r_word_valid <= 1'b1;
                    r_word       <= w_padded;
                    r_byte_idx   <= '0;
                end else begin
                    r_byte_idx <= r_byte_idx + 2'd1;
                end
            end
        end
    end

    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

endmodule

`default_nettype wire

// File: rtl/im_loader.sv
// ============================================================================
// Module      : im_loader
// Description : Loads a byte-stream program image into the instruction memory
//               from word 0 and holds the CPU in reset until it completes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module im_loader #(
    parameter int IM_DEPTH = im_loader_pkg::IM_DEPTH,
    parameter int ADDR_W   = im_loader_pkg::ADDR_W
) (
    input  wire logic   clk,
    input  wire logic   reset,
    im_loader_if.slave  bus
);

    import im_loader_pkg::*;

    localparam logic [ADDR_W:0] c_full = (ADDR_W+1)'(IM_DEPTH);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W:0]   r_word_count;
    logic [ADDR_W-1:0] r_im_addr;

    logic        w_in_ready;
    logic        w_done;
    logic        w_cpu_reset;
    logic        w_overflow;
    logic        w_start_load;
    logic        w_xfer;
    logic        w_full;
    logic        w_accept;
    logic        w_word_done;
    logic        w_im_we;
    logic [31:0] w_im_wdata;

    assign w_xfer   = bus.in_valid && w_in_ready;
    assign w_full   = (r_word_count == c_full);
    assign w_accept = w_xfer && !w_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_start_load = 1'b0;
        w_in_ready   = 1'b0;
        w_done       = 1'b0;
        w_cpu_reset  = 1'b1;
        w_overflow   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next       = LOAD;
                    w_start_load = 1'b1;
                end
            end
            LOAD: begin
                w_in_ready = 1'b1;
                if (w_xfer) begin
                    if (w_full) begin
                        w_next = ERROR;
                    end else if (bus.in_last) begin
                        w_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                w_next = DONE;
            end
            DONE: begin
                w_done      = 1'b1;
                w_cpu_reset = 1'b0;
                if (bus.start) begin
                    w_next       = LOAD;
                    w_start_load = 1'b1;
                end
            end
            ERROR: begin
                w_overflow = 1'b1;
                if (bus.start) begin
                    w_next       = LOAD;
                    w_start_load = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    im_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_start_load),
        .i_accept     (w_accept),
        .i_last       (bus.in_last),
        .i_data       (bus.in_data),
        .o_word_done  (w_word_done),
        .o_word_valid (w_im_we),
        .o_word       (w_im_wdata)
    );

    // Address is captured alongside the data so both line up with im_we.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word_count <= '0;
            r_im_addr    <= '0;
        end else if (w_start_load) begin
            r_word_count <= '0;
        end else if (w_word_done) begin
            r_im_addr    <= r_word_count[ADDR_W-1:0];
            r_word_count <= r_word_count + (ADDR_W+1)'(1);
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.im_we      = w_im_we;
    assign bus.im_addr    = r_im_addr;
    assign bus.im_wdata   = w_im_wdata;
    assign bus.cpu_reset  = w_cpu_reset;
    assign bus.done       = w_done;
    assign bus.overflow   = w_overflow;
    assign bus.word_count = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_im_loader.sv
// ============================================================================
// Module      : tb_im_loader
// Description : Scoreboard bench for im_loader with a small IM depth.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_im_loader;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    im_loader_if #(.ADDR_W(AW)) bus ();

    im_loader #(.IM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_err    = 0;
    int          exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            if (exp_data.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL spurious_write: im_we at addr %0h data %08h, expected none",
                         bus.im_addr, bus.im_wdata);
            end else begin
                chk("write_addr", 32'(bus.im_addr), 32'(exp_addr.pop_front()));
                chk("write_data", bus.im_wdata, exp_data.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input int gap_pct);
        logic ok;
        for (int g = 0; g < 4 && int'($urandom_range(0, 99)) < gap_pct; g++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.in_last  = last;
        ok = 1'b0;
        for (int k = 0; k < 8 && !ok; k++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!ok) begin
            n_checks++;
            n_err++;
            $display("FAIL accept_timeout: byte %02h never accepted", b);
        end
    endtask

    // Reference: words are the image cut into groups of four bytes, first byte
    // most significant, zero-filled at the tail, written to consecutive words.
    task automatic expect_words(input logic [7:0] img[$], output int nw);
        logic [31:0] w;
        nw = (img.size() + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++)
                if (4*i + j < img.size())
                    w = w | (32'(img[4*i + j]) << (24 - 8*j));
            exp_addr.push_back(i);
            exp_data.push_back(w);
        end
    endtask

    // Assumes the loader is already in LOAD; poke_at >= 0 pulses start mid-image.
    task automatic run_image(input logic [7:0] img[$], input int gap_pct, input int poke_at);
        int nw;
        expect_words(img, nw);
        for (int i = 0; i < img.size(); i++) begin
            if (i == poke_at) pulse_start();
            send_byte(img[i], (i == img.size() - 1), gap_pct);
        end
        chk("im_we_after_last", 32'(bus.im_we), 32'd1);
        chk("done_early", 32'(bus.done), 32'd0);
        chk("cpu_reset_early", 32'(bus.cpu_reset), 32'd1);
        tick();
        chk("done", 32'(bus.done), 32'd1);
        chk("cpu_reset_released", 32'(bus.cpu_reset), 32'd0);
        chk("in_ready_done", 32'(bus.in_ready), 32'd0);
        chk("word_count", 32'(bus.word_count), 32'(nw));
        chk("scoreboard_drained", 32'(exp_data.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] img[$];
        int         len;

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        reset        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_im_we", 32'(bus.im_we), 32'd0);
        chk("rst_im_addr", 32'(bus.im_addr), 32'd0);
        chk("rst_im_wdata", bus.im_wdata, 32'd0);
        chk("rst_word_count", 32'(bus.word_count), 32'd0);
        reset = 1'b0;

        // Bytes offered while idle must be ignored.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = 8'($urandom);
            bus.in_last = 1'($urandom);
            tick();
            chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("idle_word_count", 32'(bus.word_count), 32'd0);
        chk("idle_cpu_reset", 32'(bus.cpu_reset), 32'd1);

        // Directed full image.
        pulse_start();
        chk("load_in_ready", 32'(bus.in_ready), 32'd1);
        img = '{8'h34, 8'h08, 8'h00, 8'h01, 8'hAC, 8'h08, 8'h00, 8'h00};
        run_image(img, 0, -1);

        // Restart from DONE, then a partial tail.
        pulse_start();
        chk("restart_done", 32'(bus.done), 32'd0);
        chk("restart_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("restart_word_count", 32'(bus.word_count), 32'd0);
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_image(img, 0, -1);

        // Gapped stream with a start pulse during LOAD that must be ignored.
        pulse_start();
        img = '{8'h34, 8'h08, 8'h00, 8'h01, 8'hAC, 8'h08, 8'h00, 8'h00};
        run_image(img, 40, 3);

        // Randomised images up to the full depth.
        for (int t = 0; t < 8; t++) begin
            pulse_start();
            len = $urandom_range(1, 4*DEPTH);
            img = {};
            for (int i = 0; i < len; i++) img.push_back(8'($urandom));
            run_image(img, $urandom_range(0, 50), $urandom_range(0, 1) ? int'($urandom_range(0, len - 1)) : -1);
        end

        // Exact fill to IM_DEPTH words completes normally.
        pulse_start();
        img = {};
        for (int i = 0; i < 4*DEPTH; i++) img.push_back(8'($urandom));
        run_image(img, 10, -1);

        // Overflow: the byte after a full IM is discarded and latches ERROR.
        pulse_start();
        img = {};
        for (int i = 0; i < 4*DEPTH; i++) img.push_back(8'($urandom));
        begin
            int nw;
            expect_words(img, nw);
        end
        for (int i = 0; i < 4*DEPTH; i++) send_byte(img[i], 1'b0, 20);
        tick();
        chk("full_word_count", 32'(bus.word_count), 32'(DEPTH));
        chk("full_overflow", 32'(bus.overflow), 32'd0);
        send_byte(8'hEE, 1'($urandom), 0);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        chk("ovf_in_ready", 32'(bus.in_ready), 32'd0);
        chk("ovf_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("ovf_done", 32'(bus.done), 32'd0);
        bus.in_valid = 1'b1;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        chk("ovf_word_count", 32'(bus.word_count), 32'(DEPTH));
        pulse_start();
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);
        chk("ovf_restart_wc", 32'(bus.word_count), 32'd0);
        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_image(img, 0, -1);

        // Asynchronous reset in the middle of a word.
        pulse_start();
        send_byte(8'hA5, 1'b0, 0);
        send_byte(8'h5A, 1'b0, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("arst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_word_count", 32'(bus.word_count), 32'd0);
        chk("arst_im_wdata", bus.im_wdata, 32'd0);
        chk("arst_im_we", 32'(bus.im_we), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        pulse_start();
        img = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
        run_image(img, 0, -1);

        repeat (3) tick();
        chk("final_drained", 32'(exp_data.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
